// File: rtl/audio_mixer_out.sv
// rtl/audio_mixer_out.sv - music/SFX mixer with tone synthesis, PWM volume gate and registered speaker drive
module audio_mixer_out #(
  parameter int unsigned HIT_HP_START    = 50000,
  parameter int unsigned HIT_HP_STEP     = 2500,
  parameter int unsigned HIT_STEP_CYCLES = 1000000,
  parameter int unsigned HIT_DUR         = 15000000,
  parameter int unsigned BLOCK_HP        = 25000,
  parameter int unsigned BLOCK_DUR       = 8000000,
  parameter int unsigned CW              = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       music_in,
  input  logic       hit_trig,
  input  logic       block_trig,
  input  logic       mute,
  input  logic [2:0] volume,
  output logic       speaker,
  output logic       sfx_active
);

  localparam logic [CW-1:0] HIT_HP_INIT = CW'(HIT_HP_START);
  localparam logic [CW-1:0] BLOCK_HP_C  = CW'(BLOCK_HP);
  localparam logic [CW-1:0] HIT_LAST    = CW'(HIT_DUR - 1);
  localparam logic [CW-1:0] BLOCK_LAST  = CW'(BLOCK_DUR - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(HIT_STEP_CYCLES - 1);
  localparam logic [CW:0]   HP_STEP_EXT = (CW+1)'(HIT_HP_STEP);

  typedef enum logic [1:0] {IDLE, HIT, BLOCK} state_t;

  state_t        state_q, state_d;
  logic          start;
  logic          music_m, music_s;
  logic          hit_q, block_q;
  logic          hit_rise, block_rise;
  logic [CW-1:0] hp, hp_cnt, dur, step_cnt;
  logic [CW:0]   hp_sum;
  logic          tone;
  logic [2:0]    pwm_cnt;
  logic          gate, src;

  assign hit_rise   = hit_trig & ~hit_q;
  assign block_rise = block_trig & ~block_q;
  assign hp_sum     = {1'b0, hp} + HP_STEP_EXT;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit_rise) begin
          state_d = HIT;
          start   = 1'b1;
        end else if (block_rise) begin
          state_d = BLOCK;
          start   = 1'b1;
        end
      end
      HIT: begin
        if (hit_rise) start = 1'b1;
        else if (dur == HIT_LAST) state_d = IDLE;
      end
      BLOCK: begin
        // A hit always preempts a block; a new block rise restarts the block.
        if (hit_rise) begin
          state_d = HIT;
          start   = 1'b1;
        end else if (block_rise) begin
          start = 1'b1;
        end else if (dur == BLOCK_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      music_m <= 1'b0;
      music_s <= 1'b0;
      hit_q   <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      music_m <= music_in;
      music_s <= music_m;
      hit_q   <= hit_trig;
      block_q <= block_trig;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp       <= '0;
      hp_cnt   <= '0;
      dur      <= '0;
      step_cnt <= '0;
      tone     <= 1'b0;
    end else if (start) begin
      hp       <= (state_d == HIT) ? HIT_HP_INIT : BLOCK_HP_C;
      hp_cnt   <= '0;
      dur      <= '0;
      step_cnt <= '0;
      tone     <= 1'b0;
    end else if (state_d == IDLE) begin
      hp_cnt   <= '0;
      dur      <= '0;
      step_cnt <= '0;
      tone     <= 1'b0;
    end else begin
      dur <= dur + 1'b1;
      if (hp_cnt == hp - 1'b1) begin
        hp_cnt <= '0;
        tone   <= ~tone;
      end else begin
        hp_cnt <= hp_cnt + 1'b1;
      end
      // Downward pitch sweep: lengthen the half-period, saturating at the counter maximum.
      if (state_q == HIT) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          hp       <= hp_sum[CW] ? '1 : hp_sum[CW-1:0];
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

  assign gate = (volume == 3'd7) || (pwm_cnt < volume);
  assign src  = (state_q == IDLE) ? music_s : tone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt    <= '0;
      speaker    <= 1'b0;
      sfx_active <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      speaker    <= src & gate & ~mute;
      sfx_active <= (state_q != IDLE);
    end
  end

endmodule

// File: tb/tb_audio_mixer_out.sv
// tb/tb_audio_mixer_out.sv - scoreboard and table-driven bench for audio_mixer_out
module tb_audio_mixer_out;

  localparam int HIT_TOG[8] = '{4, 8, 12, 16, 22, 28, 36, 44};

  logic       clk = 1'b0;
  logic       reset;
  logic       music_in, hit_trig, block_trig, mute;
  logic [2:0] volume;
  logic       speaker, sfx_active;

  always #5 clk = ~clk;

  audio_mixer_out #(
    .HIT_HP_START(4), .HIT_HP_STEP(2), .HIT_STEP_CYCLES(16), .HIT_DUR(48),
    .BLOCK_HP(3), .BLOCK_DUR(20), .CW(24)
  ) dut (
    .clk(clk), .reset(reset), .music_in(music_in), .hit_trig(hit_trig),
    .block_trig(block_trig), .mute(mute), .volume(volume),
    .speaker(speaker), .sfx_active(sfx_active)
  );

  typedef struct {
    int    due;
    logic  spk;
    logic  sfx;
    string name;
  } exp_t;

  typedef struct {
    logic [2:0] vol;
    logic       mt;
    logic       mus;
    int         exp_high;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic expect_at(input int due, input logic spk, input logic sfx, input string name);
    exp_t e;
    e.due = due;
    e.spk = spk;
    e.sfx = sfx;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check({e.name, " speaker"}, speaker, e.spk);
      check({e.name, " sfx_active"}, sfx_active, e.sfx);
    end
  endtask

  function automatic logic hit_tone(input int j);
    int n = 0;
    for (int i = 0; i < 8; i++) if (HIT_TOG[i] <= j) n++;
    return n[0];
  endfunction

  function automatic logic block_tone(input int j);
    return ((j / 3) % 2) == 1;
  endfunction

  task automatic run_hit(input bit with_block, input bit block_mid, input bit mute_on, input string name);
    int e;
    e = cyc + 1;
    for (int k = 1; k <= 48; k++) expect_at(e + k, mute_on ? 1'b0 : hit_tone(k - 1), 1'b1, name);
    expect_at(e + 49, mute_on ? 1'b0 : 1'b1, 1'b0, {name, " end"});
    hit_trig = 1'b1;
    block_trig = with_block;
    mute = mute_on;
    tick();
    hit_trig = 1'b0;
    block_trig = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      block_trig = block_mid && (k == 20);
      if (k == 30) music_in = 1'b1;
      tick();
    end
    block_trig = 1'b0;
    music_in = 1'b0;
    mute = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int b, e, cnt;
    reset = 1'b1;
    music_in = 1'b0;
    hit_trig = 1'b0;
    block_trig = 1'b0;
    mute = 1'b0;
    volume = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset speaker", speaker, 1'b0);
    check("reset sfx_active", sfx_active, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // Idle passthrough: music toggles every 10 cycles, speaker follows 3 edges later.
    for (int c = 0; c < 60; c++) begin
      music_in = ((c / 10) % 2) == 1;
      expect_at(cyc + 3, music_in, 1'b0, "passthrough");
      tick();
    end
    music_in = 1'b0;
    repeat (5) tick();

    run_hit(1'b0, 1'b0, 1'b0, "hit sweep");
    run_hit(1'b1, 1'b1, 1'b0, "hit priority");
    run_hit(1'b0, 1'b0, 1'b1, "hit muted");

    // Hit preempts a block at block cycle 10.
    b = cyc + 1;
    for (int k = 1; k <= 10; k++) expect_at(b + k, block_tone(k - 1), 1'b1, "preempt block");
    e = b + 10;
    for (int k = 1; k <= 48; k++) expect_at(e + k, hit_tone(k - 1), 1'b1, "preempt hit");
    expect_at(e + 49, 1'b0, 1'b0, "preempt end");
    block_trig = 1'b1;
    tick();
    block_trig = 1'b0;
    repeat (9) tick();
    hit_trig = 1'b1;
    tick();
    hit_trig = 1'b0;
    repeat (53) tick();

    // Held block trigger fires only once.
    b = cyc + 1;
    for (int k = 1; k <= 20; k++) expect_at(b + k, block_tone(k - 1), 1'b1, "held block");
    for (int k = 21; k <= 30; k++) expect_at(b + k, 1'b0, 1'b0, "held block after");
    block_trig = 1'b1;
    repeat (100) tick();
    block_trig = 1'b0;
    repeat (4) tick();

    // Block retrigger at block cycle 15 extends to 35 cycles.
    b = cyc + 1;
    for (int k = 1; k <= 15; k++) expect_at(b + k, block_tone(k - 1), 1'b1, "retrig first");
    for (int k = 16; k <= 35; k++) expect_at(b + k, block_tone(k - 16), 1'b1, "retrig second");
    expect_at(b + 36, 1'b0, 1'b0, "retrig end");
    block_trig = 1'b1;
    tick();
    block_trig = 1'b0;
    repeat (14) tick();
    block_trig = 1'b1;
    tick();
    block_trig = 1'b0;
    repeat (25) tick();

    // Volume / mute table: count speaker-high cycles over two PWM periods.
    vecs[0] = '{3'd3, 1'b0, 1'b1, 6};
    vecs[1] = '{3'd0, 1'b0, 1'b1, 0};
    vecs[2] = '{3'd7, 1'b0, 1'b1, 16};
    vecs[3] = '{3'd5, 1'b0, 1'b1, 10};
    vecs[4] = '{3'd1, 1'b0, 1'b1, 2};
    vecs[5] = '{3'd7, 1'b1, 1'b1, 0};
    vecs[6] = '{3'd7, 1'b0, 1'b0, 0};
    vecs[7] = '{3'd4, 1'b1, 1'b1, 0};
    for (int v = 0; v < 8; v++) begin
      volume = vecs[v].vol;
      mute = vecs[v].mt;
      music_in = vecs[v].mus;
      repeat (4) tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (speaker === 1'b1) cnt++;
      end
      check_int($sformatf("volume vec %0d high count", v), cnt, vecs[v].exp_high);
    end
    volume = 3'd7;
    mute = 1'b0;
    music_in = 1'b0;
    repeat (5) tick();

    // Asynchronous reset in the middle of a hit.
    e = cyc + 1;
    for (int k = 1; k <= 20; k++) expect_at(e + k, hit_tone(k - 1), 1'b1, "pre-reset hit");
    hit_trig = 1'b1;
    tick();
    hit_trig = 1'b0;
    repeat (20) tick();
    music_in = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("async reset sfx_active", sfx_active, 1'b0);
    check("async reset speaker", speaker, 1'b0);
    tick();
    reset = 1'b0;
    expect_at(cyc + 1, 1'b0, 1'b0, "post-reset clk1");
    expect_at(cyc + 2, 1'b0, 1'b0, "post-reset clk2");
    expect_at(cyc + 3, 1'b1, 1'b0, "post-reset clk3");
    repeat (4) tick();

    check_int("scoreboard drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer_out.md
Name: audio_mixer_out

Overview:
- Final audio stage between the background-music generators and the board speaker pin.
- Takes the 1-bit square-wave music stream and two sound-effect triggers (hit, block).
- Synthesises the SFX tones internally. An active SFX replaces (ducks) the music.
- Applies mute and a 3-bit PWM volume gate, then drives the registered speaker output.

Parameters:
- HIT_HP_START, 50000: initial half-period of the hit tone in clk cycles (1 kHz at 100 MHz).
- HIT_HP_STEP, 2500: amount added to the hit half-period at each sweep step (downward pitch sweep).
- HIT_STEP_CYCLES, 1000000: clk cycles between sweep steps.
- HIT_DUR, 15000000: hit SFX length in clk cycles.
- BLOCK_HP, 25000: fixed half-period of the block tone.
- BLOCK_DUR, 8000000: block SFX length in clk cycles.
- CW, 24: width of all duration and half-period counters.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- music_in  in  1  square-wave music from the music generator; may change at any time
- hit_trig  in  1  hit SFX request, level; acted on at rising edge
- block_trig  in  1  block SFX request, level; acted on at rising edge
- mute  in  1  1 forces speaker low
- volume  in  3  0 = silent, 7 = full
- speaker  out  1  registered speaker drive
- sfx_active  out  1  1 while the FSM is in HIT or BLOCK

Behaviour:
- Reset (async, immediate) clears everything:
  - speaker=0, sfx_active=0, FSM=IDLE
  - all counters=0, tone bit=0, PWM counter=0
  - trigger edge registers=0, synchroniser flops=0
- music_in input path: 2-flop synchroniser gives music_s. music_in reaches speaker in 3 cycles (2 sync + output register).
- Trigger edge detect: each trigger has a previous-value register. rise = trig & ~trig_q. A trigger held high fires once.
- FSM states: IDLE, HIT, BLOCK.
  - IDLE: on hit rise go to HIT; else on block rise go to BLOCK. Simultaneous rises: HIT wins.
  - HIT: a hit rise restarts HIT (re-entry). Block rises are ignored. After the dur counter reaches HIT_DUR-1, go to IDLE.
  - BLOCK: a hit rise preempts into HIT. A block rise restarts BLOCK. After the dur counter reaches BLOCK_DUR-1, go to IDLE.
- Actions on every entry or re-entry into a tone state, in the same edge as the transition:
  - dur=0, hp_cnt=0, step_cnt=0, tone=0
  - hp = HIT_HP_START for HIT, BLOCK_HP for BLOCK
- Tone generation (per cycle in HIT/BLOCK):
  - If hp_cnt==hp-1: hp_cnt=0 and tone toggles. Else hp_cnt+1.
  - dur increments every cycle.
- Hit sweep (HIT only):
  - step_cnt counts 0..HIT_STEP_CYCLES-1. At wrap, hp = hp + HIT_HP_STEP, saturating at 2^CW-1.
  - A new hp takes effect at the next compare. If hp_cnt is already ≥ the new hp-1, it still counts up to the new hp-1 (no early toggle).
- Source select: src = tone in HIT/BLOCK, music_s in IDLE. tone is forced 0 in IDLE.
- Volume gate:
  - 3-bit pwm_cnt increments every clk, free-running, wraps 7→0.
  - gate = 1 when volume==7; otherwise gate = (pwm_cnt < volume).
- Output: speaker register <= src & gate & ~mute.
  - Mute does not stop the FSM or its counters.
  - Changes to volume or mute take effect on the next clk edge.
- sfx_active: registered. It is 1 on the cycle after entering HIT/BLOCK and 0 on the cycle after returning to IDLE.
- Reset mid-SFX: the SFX is abandoned, the block returns to IDLE, and music resumes after the 3-cycle path once reset is released.
- Counter width: hp, hp_cnt, dur and step_cnt are all CW bits. Every parameter must be ≤ 2^CW-1.

Test Plan:
All scenarios use HIT_HP_START=4, HIT_HP_STEP=2, HIT_STEP_CYCLES=16, HIT_DUR=48, BLOCK_HP=3, BLOCK_DUR=20, volume=7, mute=0 unless stated.
- Idle passthrough: music_in toggles every 10 cycles. Required: speaker is music_in delayed 3 cycles, sfx_active=0.
- Hit sweep: one-cycle hit_trig pulse. Required:
  - speaker toggles every 4 cycles for 16 cycles, then every 6 cycles, then every 8 cycles.
  - sfx_active is high for exactly 48 cycles.
  - Music returns afterwards.
- Priority and preemption:
  - hit_trig and block_trig rise in the same cycle → HIT.
  - block_trig during HIT → ignored (HIT still ends at cycle 48).
  - hit_trig at cycle 10 of BLOCK → HIT restarts with half-period 4.
- Retrigger and held level:
  - Hold block_trig high for 100 cycles → only one BLOCK of 20 cycles (period 6).
  - A second rise at BLOCK cycle 15 → BLOCK lasts 15+20 cycles in total.
- Volume and mute:
  - music_in=1 constant, volume=3 → speaker high 3 of every 8 cycles.
  - volume=0 → speaker constantly 0.
  - mute=1 during HIT → speaker 0 while sfx_active still deasserts on schedule.
- Async reset: assert reset at HIT cycle 20, asynchronously between edges. Required:
  - speaker and sfx_active go to 0 immediately.
  - After release with music_in=1, speaker=1 on the 3rd clk.
